// File: rtl/data_mem_unit.sv
// Word-organised data memory with RV32I byte/halfword/word access and a fixed wait-state handshake.
// Optional trap on misaligned halfword/word accesses: define DMEM_MISALIGN_TRAP_EN.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_input,
  input  logic        mem_enable,
  input  logic        mem_r_w,
  input  logic [2:0]  mem_funct3,
  output logic [31:0] mem_output,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_misaligned
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt, wait_nxt;
  logic [AW+1:0]   addr_q;
  logic [31:0]     data_q;
  logic [2:0]      f3_q;
  logic            rw_q;
  logic [31:0]     out_q;
  logic            mis_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [31:0]     rd_word;
  logic [31:0]     wr_word;
  logic            wr_en;
  logic [31:0]     ld_val;
  logic            misaligned;
  logic            accept;
  logic            complete;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign idx      = addr_q[AW+1:2];
  assign rd_word  = mem[idx];
  assign accept   = (state == IDLE) && mem_enable;
  assign complete = (state == ACCESS) && (wait_cnt == 4'd0);
  assign ld_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half  = rd_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    misaligned = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (f3_q == 3'b010)
      misaligned = (addr_q[1:0] != 2'b00);
    else if ((f3_q == 3'b001) || (!rw_q && (f3_q == 3'b101)))
      misaligned = addr_q[0];
`endif
  end

  // Store data is merged into the current word so only the addressed lanes change.
  always_comb begin
    wr_word = rd_word;
    wr_en   = 1'b0;
    if (rw_q && !misaligned) begin
      case (f3_q)
        3'b000: begin
          wr_en = 1'b1;
          wr_word[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
        end
        3'b001: begin
          wr_en = 1'b1;
          wr_word[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
        3'b010: begin
          wr_en   = 1'b1;
          wr_word = data_q;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (f3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = rd_word;
    endcase
    if (misaligned)
      ld_val = '0;
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      IDLE: begin
        if (mem_enable) begin
          state_nxt = ACCESS;
          wait_nxt  = WAIT_STATES[3:0];
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0)
          state_nxt = RESP;
        else
          wait_nxt = wait_cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      f3_q     <= '0;
      rw_q     <= 1'b0;
      out_q    <= '0;
      mis_q    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++)
        mem[i] <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (accept) begin
        addr_q <= mem_address[AW+1:0];
        data_q <= mem_input;
        f3_q   <= mem_funct3;
        rw_q   <= mem_r_w;
      end
      if (complete) begin
        mis_q <= misaligned;
        if (wr_en)
          mem[idx] <= wr_word;
        if (!rw_q)
          out_q <= ld_val;
      end
    end
  end

  assign mem_output     = out_q;
  assign mem_ready      = (state == RESP);
  assign mem_busy       = (state != IDLE);
  assign mem_misaligned = (state == RESP) && mis_q;

endmodule
